// File: rtl/tap_port_arbiter.sv
// Single-port tap BRAM arbiter: engine has fixed priority, host gets the leftover cycles; reads return one cycle after grant.
// Define TAP_ARB_STARVE_GUARD_EN to add a host starvation guard that forces a host grant after STARVE_MAX denied cycles.
module tap_port_arbiter #(
  parameter int pADDR_WIDTH = 12,
  parameter int pDATA_WIDTH = 32,
  parameter int STARVE_MAX  = 4
) (
  input  logic                   axis_clk,
  input  logic                   axis_rst,
  input  logic                   host_req,
  input  logic                   host_we,
  input  logic [pADDR_WIDTH-1:0] host_addr,
  input  logic [pDATA_WIDTH-1:0] host_wdata,
  output logic                   host_gnt,
  output logic                   host_rvalid,
  output logic [pDATA_WIDTH-1:0] host_rdata,
  input  logic                   eng_req,
  input  logic [pADDR_WIDTH-1:0] eng_addr,
  output logic                   eng_gnt,
  output logic                   eng_rvalid,
  output logic [pDATA_WIDTH-1:0] eng_rdata,
  output logic [3:0]             tap_WE,
  output logic                   tap_EN,
  output logic [pDATA_WIDTH-1:0] tap_Di,
  output logic [pADDR_WIDTH-1:0] tap_A,
  input  logic [pDATA_WIDTH-1:0] tap_Do
);

  logic                   w_force;
  logic                   r_host_rd;
  logic                   r_eng_rd;
  logic [pDATA_WIDTH-1:0] r_host_rdata;

`ifdef TAP_ARB_STARVE_GUARD_EN
  logic [3:0] r_starve_cnt;

  // Saturates at the limit; a request that is withdrawn or served restarts the count.
  always_ff @(posedge axis_clk) begin
    if (axis_rst) begin
      r_starve_cnt <= '0;
    end else if (host_gnt || !host_req) begin
      r_starve_cnt <= '0;
    end else if (r_starve_cnt != 4'(STARVE_MAX)) begin
      r_starve_cnt <= r_starve_cnt + 4'd1;
    end
  end

  assign w_force = host_req && (r_starve_cnt == 4'(STARVE_MAX));
`else
  assign w_force = 1'b0;
`endif

  assign eng_gnt  = !axis_rst && eng_req && !w_force;
  assign host_gnt = !axis_rst && host_req && !eng_gnt;

  always_comb begin
    tap_A  = '0;
    tap_EN = 1'b0;
    if (eng_gnt) begin
      tap_A  = eng_addr;
      tap_EN = 1'b1;
    end else if (host_gnt) begin
      tap_A  = host_addr;
      tap_EN = 1'b1;
    end
  end

  assign tap_WE = {4{host_gnt & host_we}};
  assign tap_Di = host_wdata;

  // One owner bit per side is enough since at most one grant is issued per cycle.
  always_ff @(posedge axis_clk) begin
    if (axis_rst) begin
      r_host_rd    <= 1'b0;
      r_eng_rd     <= 1'b0;
      r_host_rdata <= '0;
    end else begin
      r_host_rd <= host_gnt & ~host_we;
      r_eng_rd  <= eng_gnt;
      if (r_host_rd) begin
        r_host_rdata <= tap_Do;
      end
    end
  end

  assign host_rvalid = r_host_rd;
  assign host_rdata  = r_host_rd ? tap_Do : r_host_rdata;
  assign eng_rvalid  = r_eng_rd;
  assign eng_rdata   = r_eng_rd ? tap_Do : '0;

endmodule
